// File: rtl/ttl_bus_reg_driver.sv
// Registered, optionally inverting, multi-lane tri-state bus driver with per-lane OE arming delay.
// Optional bus contention monitor enabled by defining BUS_CONTENTION_CHECK_EN.
module ttl_bus_reg_driver #(
  parameter int WIDTH    = 8,
  parameter int LANES    = 1,
  parameter int INVERT   = 1,
  parameter int OE_DELAY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   d,
  input  logic               le,
  input  logic [LANES-1:0]   oe_n,
  output wire  [WIDTH-1:0]   bus,
  output logic [WIDTH-1:0]   q,
  output logic [LANES-1:0]   drive,
  input  logic [WIDTH-1:0]   bus_in,
  input  logic               clr_cont,
  output logic               contention,
  output logic [15:0]        cont_count
);

  localparam int LW = WIDTH / LANES;
  localparam logic [3:0] ARM_LAST = 4'(OE_DELAY - 1);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_ARMING = 2'd1,
    ST_ON     = 2'd2
  } state_t;

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [LANES-1:0] drive_q;

  always_comb begin
    data_d = data_q;
    if (le) begin
      data_d = (INVERT != 0) ? ~d : d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q     = data_q;
  assign drive = drive_q;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      state_t     state_q;
      state_t     state_d;
      logic [3:0] cnt_q;
      logic [3:0] cnt_d;
      logic       lane_drive_q;

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
          ST_OFF: begin
            if (!oe_n[gi]) begin
              if (OE_DELAY <= 1) begin
                state_d = ST_ON;
                cnt_d   = 4'd0;
              end else begin
                state_d = ST_ARMING;
                cnt_d   = 4'd1;
              end
            end
          end
          ST_ARMING: begin
            // Any high sample aborts arming; the count restarts from OFF.
            if (oe_n[gi]) begin
              state_d = ST_OFF;
              cnt_d   = 4'd0;
            end else if (cnt_q == ARM_LAST) begin
              state_d = ST_ON;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
          ST_ON: begin
            if (oe_n[gi]) begin
              state_d = ST_OFF;
              cnt_d   = 4'd0;
            end
          end
          default: begin
            state_d = ST_OFF;
            cnt_d   = 4'd0;
          end
        endcase
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q      <= ST_OFF;
          cnt_q        <= 4'd0;
          lane_drive_q <= 1'b0;
        end else begin
          state_q      <= state_d;
          cnt_q        <= cnt_d;
          lane_drive_q <= (state_d == ST_ON);
        end
      end

      assign drive_q[gi] = lane_drive_q;
      // Bus follows data_q combinationally so a load shows on a driving lane at once.
      assign bus[gi*LW +: LW] = lane_drive_q ? data_q[gi*LW +: LW] : {LW{1'bz}};
    end
  endgenerate

`ifdef BUS_CONTENTION_CHECK_EN
  logic [LANES-1:0] lane_mismatch;
  logic             contention_q;
  logic             contention_d;
  logic [15:0]      cont_count_q;
  logic [15:0]      cont_count_d;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_mon
      assign lane_mismatch[gi] = drive_q[gi] &&
                                 (bus_in[gi*LW +: LW] != data_q[gi*LW +: LW]);
    end
  endgenerate

  always_comb begin
    contention_d = contention_q;
    cont_count_d = cont_count_q;
    if (clr_cont) begin
      contention_d = 1'b0;
      cont_count_d = 16'd0;
    end else if (|lane_mismatch) begin
      contention_d = 1'b1;
      if (cont_count_q != 16'hFFFF) begin
        cont_count_d = cont_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      contention_q <= 1'b0;
      cont_count_q <= 16'd0;
    end else begin
      contention_q <= contention_d;
      cont_count_q <= cont_count_d;
    end
  end

  assign contention = contention_q;
  assign cont_count = cont_count_q;
`else
  logic unused_monitor_inputs;
  assign unused_monitor_inputs = ^{bus_in, clr_cont};
  assign contention = 1'b0;
  assign cont_count = 16'd0;
`endif

endmodule
